// File: rtl/prog_fetch.sv
// Instruction-fetch stage: program RAM, PC, byte-stream loader.
// Issues one code word per 2-cycle FETCH/EXEC pair to the bus stage.
module prog_fetch #(
  parameter int         DEPTH     = 256,
  parameter logic [7:0] HALT_CODE = 8'hFF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             load_err,
  input  logic             run_start,
  input  logic             run_abort,
  input  logic [7:0]       pc_next,
  output logic [7:0]       code_out,
  output logic             code_valid,
  output logic [7:0]       pc,
  output logic [8:0]       prog_len,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_EXEC, S_HALT
  } state_e;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_e           state_q, state_d;
  logic [8:0]       load_addr_q, load_addr_d;
  logic [8:0]       prog_len_q, prog_len_d;
  logic             load_err_q, load_err_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] mem [DEPTH];
  logic       mem_we;
  logic [7:0] mem_waddr;

  logic idle_or_halt, load_start, load_more;
  logic run_go, pc_past_end, is_halt_code;

  assign idle_or_halt = (state_q == S_IDLE) ||
                        (state_q == S_HALT && !run_abort);
  assign load_start   = load_valid && idle_or_halt;
  assign load_more    = load_valid && (state_q == S_LOAD);
  assign run_go       = run_start && !load_valid &&
                        ((state_q == S_IDLE && prog_len_q != 9'd0) ||
                         (state_q == S_HALT && !run_abort));
  assign pc_past_end  = {1'b0, pc_q} >= prog_len_q;
  assign is_halt_code = code_q == HALT_CODE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_addr_q <= 9'd0;
      prog_len_q  <= 9'd0;
      load_err_q  <= 1'b0;
      pc_q        <= 8'd0;
      code_q      <= 8'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      prog_len_q  <= prog_len_d;
      load_err_q  <= load_err_d;
      pc_q        <= pc_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
    end
  end

  // RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_valid)
          state_d = load_last ? S_IDLE : S_LOAD;
        else if (run_go)
          state_d = S_FETCH;
      end
      S_LOAD: begin
        if (load_valid && load_last) state_d = S_IDLE;
      end
      S_FETCH: begin
        if (run_abort)        state_d = S_IDLE;
        else if (pc_past_end) state_d = S_HALT;
        else                  state_d = S_EXEC;
      end
      S_EXEC: begin
        if (run_abort)         state_d = S_IDLE;
        else if (is_halt_code) state_d = S_HALT;
        else                   state_d = S_FETCH;
      end
      S_HALT: begin
        if (run_abort)       state_d = S_IDLE;
        else if (load_valid) state_d = load_last ? S_IDLE : S_LOAD;
        else if (run_start)  state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_addr_d = load_addr_q;
    prog_len_d  = prog_len_q;
    load_err_d  = load_err_q;
    pc_d        = pc_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = load_addr_q[7:0];
    if (load_start) begin
      mem_we      = 1'b1;
      mem_waddr   = 8'd0;
      load_addr_d = 9'd1;
      load_err_d  = 1'b0;
      if (load_last) prog_len_d = 9'd1;
    end else if (load_more) begin
      if (load_addr_q < DEPTH_L) begin
        mem_we      = 1'b1;
        load_addr_d = load_addr_q + 9'd1;
      end else begin
        load_err_d  = 1'b1;
      end
      if (load_last) prog_len_d = load_addr_d;
    end
    if (run_go) begin
      pc_d  = 8'd0;
      cnt_d = '0;
    end
    if (state_q == S_FETCH && !run_abort && !pc_past_end)
      code_d = mem[pc_q];
    if (state_q == S_EXEC && !run_abort && !is_halt_code) begin
      pc_d = pc_next;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
    if (run_abort && (state_q == S_FETCH ||
        state_q == S_EXEC || state_q == S_HALT))
      pc_d = 8'd0;
  end

  always_comb begin
    load_ready = 1'b0;
    code_valid = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      S_IDLE:  load_ready = 1'b1;
      S_LOAD:  load_ready = 1'b1;
      S_EXEC:  code_valid = 1'b1;
      S_HALT: begin
        load_ready = 1'b1;
        halted     = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      load_ready = 1'b0;
      code_valid = 1'b0;
      halted     = 1'b0;
    end
  end

  assign load_err    = load_err_q;
  assign code_out    = code_q;
  assign pc          = pc_q;
  assign prog_len    = prog_len_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/prog_fetch.md
Name: prog_fetch

Overview:
Instruction-fetch stage directly upstream of the 8-bit bus/decode stage.
- Holds the program RAM and the program counter.
- Presents one 8-bit code word per instruction on code_out; this feeds the bus stage's code_in.
- Takes the next address back from the bus stage's code_addr_out, so jumps and fall-through are both decided downstream.
- Includes a byte-stream loader for filling program RAM before a run.

Parameters:
DEPTH, 256, program RAM words (8-bit each); address width fixed at 8
HALT_CODE, 8'hFF, code word that stops execution when fetched
CNT_W, 16, width of the executed-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
load_valid  in  1  loader byte present
load_data  in  8  loader byte
load_last  in  1  marks final byte of program (qualified by load_valid)
load_ready  out  1  loader may transfer this cycle
load_err  out  1  sticky: byte offered past DEPTH
run_start  in  1  begin/restart execution at address 0
run_abort  in  1  abandon run, return to IDLE
pc_next  in  8  next address from bus stage (its code_addr_out)
code_out  out  8  current instruction to bus stage code_in
code_valid  out  1  code_out holds a live instruction
pc  out  8  address of code_out
prog_len  out  9  number of loaded words (0..256)
halted  out  1  high in HALT state
instr_count  out  CNT_W  executed instructions, saturating

Behaviour:
Reset values:
- State = IDLE.
- code_out = 8'h00 (copy r0->r0, harmless).
- code_valid = 0, pc = 0, prog_len = 0, load_err = 0, halted = 0, instr_count = 0, load_ready = 0.
- RAM contents are not cleared.

Reset behaviour:
- Reset asserted mid-load or mid-run returns to IDLE next edge with the values above.

States: IDLE, LOAD, FETCH, EXEC, HALT.

IDLE:
- load_ready = 1.
- load_valid -> enter LOAD. The same-cycle byte is written at address 0; load_addr = 1; load_err cleared.
- If that byte has load_last -> stay IDLE with prog_len = 1.
- load_valid has priority over a simultaneous run_start.
- run_start with prog_len != 0 -> FETCH with pc = 0 and instr_count = 0.
- run_start with prog_len == 0 is ignored.

LOAD:
- load_ready = 1.
- Each load_valid writes load_data at load_addr, then load_addr increments.
- Once load_addr reaches DEPTH, further bytes are accepted and discarded, and load_err is set (sticky until the next load starts).
- Byte with load_last -> IDLE. prog_len = min(bytes received, DEPTH).
- run_start and run_abort are ignored.

FETCH (1 cycle):
- If pc >= prog_len -> HALT; code_valid stays 0.
- Else, next edge: code_out <= RAM[pc], code_valid <= 1 -> EXEC.
- Read latency from pc to code_out is 1 cycle.

EXEC (1 cycle):
- code_valid = 1; code_out stable for the whole cycle, so the bus stage computes pc_next combinationally.
- If code_out == HALT_CODE -> HALT. pc is unchanged and instr_count is not incremented.
- Else, next edge: pc <= pc_next, instr_count += 1 (saturating at all-ones), code_valid <= 0 -> FETCH.
- Every instruction therefore takes exactly 2 cycles.
- pc_next is sampled only in EXEC.
- pc wraps naturally at 8 bits (pc_next 8'hFF+1 is the bus stage's concern). The FETCH bound check catches any address beyond prog_len.

HALT:
- halted = 1; code_valid = 0; code_out, pc and instr_count are held.
- run_start -> FETCH with pc = 0, instr_count = 0, halted = 0.
- load_valid -> LOAD, handled as in IDLE.

run_abort:
- In FETCH, EXEC or HALT: -> IDLE next edge. code_valid = 0, halted = 0, pc = 0; instr_count is held for inspection.
- Takes priority over all other events in those states.

load_ready is 0 in FETCH and EXEC.

Test Plan:
- Load 3 bytes {8'b00_111_000, 8'b00_111_011, 8'hFF} with load_last on the 3rd -> prog_len = 3, load_err = 0, return to IDLE.
- Run that program with the bus stage returning pc+1 -> code_out = 8'h38 (valid at cycle 2 after run_start), then 8'h3B two cycles later, then HALT at pc = 2 with instr_count = 2.
- Jump: program {8'hC4, 8'h00, 8'hFF} with the bus stage returning pc_next = 2 on the first EXEC -> second fetch at pc = 2, halted after instr_count = 1.
- Fall off end: program of 2 non-HALT words with pc+1 feedback -> HALT from FETCH at pc = 2, code_valid never asserted for pc = 2, instr_count = 2.
- Overflow load: 258 bytes -> prog_len = 256, load_err = 1, RAM[255] = byte 255; a subsequent 1-byte load clears load_err.
- Abort/reset: run_abort in EXEC -> IDLE next cycle, code_valid = 0, pc = 0. rst_n low mid-LOAD -> prog_len = 0; run_start then ignored until a reload.
